mem_port_arbiter: RTL and testbench

Shares the pipeline's single-port unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage. It grants one multi-cycle access at a time and runs a fixed-latency access sequence on the memory port. It returns read data with a one-cycle ready pulse and drives stall outputs that the hazard/control logic uses to freeze the PC, IF/ID and EX/MEM registers. Instantiated inside main, between the pipeline stages and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of request/response signals between the pipeline stages, the arbiter and the memory port.
// master = pipeline stages plus memory model, slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port memory between instruction fetch and data memory.
// One fixed-latency access at a time; completion is a one-cycle ready pulse with registered data.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int                CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last_dm;
  logic             if_elig, dm_elig;
  logic             grant_if, grant_dm, done;

  // A requester still showing its ready pulse is dropping req; do not grant it again.
  assign if_elig = bus.if_req & ~bus.if_ready;
  assign dm_elig = bus.dm_req & ~bus.dm_ready;

  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
  assign bus.stall_mem = bus.dm_req & ~bus.dm_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (dm_elig && (!if_elig || !last_dm)) begin
          grant_dm = 1'b1;
          state_n  = BUSY_DM;
          cnt_n    = CNT_INIT;
        end else if (if_elig) begin
          grant_if = 1'b1;
          state_n  = BUSY_IF;
          cnt_n    = CNT_INIT;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (cnt == '0) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dm       <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= ADDR_ZERO;
      bus.mem_wdata <= DATA_ZERO;
      bus.if_rdata  <= DATA_ZERO;
      bus.dm_rdata  <= DATA_ZERO;
      bus.if_ready  <= 1'b0;
      bus.dm_ready  <= 1'b0;
    end else begin
      bus.if_ready <= done && (state == BUSY_IF);
      bus.dm_ready <= done && (state == BUSY_DM);
      if (grant_dm) begin
        last_dm       <= 1'b1;
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= bus.dm_we;
        bus.mem_addr  <= bus.dm_addr;
        bus.mem_wdata <= bus.dm_wdata;
      end else if (grant_if) begin
        last_dm      <= 1'b0;
        bus.mem_en   <= 1'b1;
        bus.mem_we   <= 1'b0;
        bus.mem_addr <= bus.if_addr;
      end else if (done) begin
        // Writes leave dm_rdata untouched; mem_addr stays on the last address.
        if (state == BUSY_IF)  bus.if_rdata <= bus.mem_rdata;
        else if (!bus.mem_we)  bus.dm_rdata <= bus.mem_rdata;
        bus.mem_en <= 1'b0;
        bus.mem_we <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized requesters,
// all checked against a transaction-level model that schedules completions by edge count.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an access owned by a requester finishes exactly MEM_LAT edges after its grant.
  int              edge_n;
  int              m_owner;       // 0 none, 1 IF, 2 DM
  int              m_grant_edge;
  bit              m_last_dm;
  logic            e_mem_en, e_mem_we, e_if_ready, e_dm_ready;
  logic [ADDR_W-1:0] e_mem_addr;
  logic [DATA_W-1:0] e_mem_wdata, e_if_rdata, e_dm_rdata;

  task automatic model_reset();
    m_owner = 0; m_last_dm = 0;
    e_mem_en = 0; e_mem_we = 0; e_if_ready = 0; e_dm_ready = 0;
    e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
  endtask

  task automatic model_edge();
    bit rdy_if = 0, rdy_dm = 0, el_if, el_dm;
    int pick = 0;
    if (m_owner != 0) begin
      if (edge_n == m_grant_edge + MEM_LAT) begin
        if (m_owner == 1) begin
          e_if_rdata = bus.mem_rdata; rdy_if = 1;
        end else begin
          if (!e_mem_we) e_dm_rdata = bus.mem_rdata;
          rdy_dm = 1;
        end
        m_owner = 0; e_mem_en = 0; e_mem_we = 0;
      end
    end else begin
      el_if = bus.if_req && !e_if_ready;
      el_dm = bus.dm_req && !e_dm_ready;
      if (el_if && el_dm) pick = m_last_dm ? 1 : 2;
      else if (el_dm)     pick = 2;
      else if (el_if)     pick = 1;
      if (pick == 2) begin
        e_mem_we = bus.dm_we; e_mem_addr = bus.dm_addr; e_mem_wdata = bus.dm_wdata;
        m_last_dm = 1;
      end else if (pick == 1) begin
        e_mem_we = 0; e_mem_addr = bus.if_addr;
        m_last_dm = 0;
      end
      if (pick != 0) begin
        m_owner = pick; m_grant_edge = edge_n; e_mem_en = 1;
      end
    end
    e_if_ready = rdy_if;
    e_dm_ready = rdy_dm;
    edge_n++;
  endtask

  task automatic compare_all();
    check("mem_en",    bus.mem_en,    e_mem_en);
    check("mem_we",    bus.mem_we,    e_mem_we);
    check("mem_addr",  bus.mem_addr,  e_mem_addr);
    if (e_mem_we) check("mem_wdata", bus.mem_wdata, e_mem_wdata);
    check("if_ready",  bus.if_ready,  e_if_ready);
    check("dm_ready",  bus.dm_ready,  e_dm_ready);
    check("if_rdata",  bus.if_rdata,  e_if_rdata);
    check("dm_rdata",  bus.dm_rdata,  e_dm_rdata);
    check("stall_if",  bus.stall_if,  bus.if_req & ~e_if_ready);
    check("stall_mem", bus.stall_mem, bus.dm_req & ~e_dm_ready);
    check("one_ready", bus.if_ready & bus.dm_ready, 1'b0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    bus.if_req = 0; bus.dm_req = 0; bus.dm_we = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int k, dm_at, if_at, we_cycles, rdy_cnt;
    int order[$];
    logic [DATA_W-1:0] saved;

    edge_n = 0;
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0;

    // Asynchronous reset before any clock edge: outputs leave X at once.
    #2 rst = 1;
    #1 model_reset();
    compare_all();
    cycle(); cycle();
    rst = 0;
    idle(2);

    // IF fetch with known data and latency.
    bus.if_req = 1; bus.if_addr = 32'h10; bus.mem_rdata = 32'hE3A01005;
    k = 0;
    while (!bus.if_ready && k < 10) begin cycle(); k++; end
    check("if_latency", k, MEM_LAT + 1);
    check("if_fetch_data", bus.if_rdata, 32'hE3A01005);
    idle(2);

    // Simultaneous requests with last grant to IF: DM first, IF in DM's ready cycle.
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h40; bus.mem_rdata = 32'h1234_5678;
    bus.if_req = 1; bus.if_addr = 32'h14;
    dm_at = -1; if_at = -1; k = 0;
    while ((dm_at < 0 || if_at < 0) && k < 20) begin
      cycle(); k++;
      if (bus.dm_ready) begin dm_at = k; bus.dm_req = 0; end
      if (bus.if_ready) begin if_at = k; bus.if_req = 0; end
      bus.mem_rdata = $urandom;
    end
    check("both_dm_cycle", dm_at, MEM_LAT + 1);
    check("both_if_cycle", if_at, 2 * (MEM_LAT + 1));
    idle(2);

    // Both held continuously: completions alternate DM, IF, DM, IF.
    bus.dm_req = 1; bus.if_req = 1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (bus.dm_ready) order.push_back(2);
      if (bus.if_ready) order.push_back(1);
      bus.if_addr = $urandom; bus.dm_addr = $urandom; bus.mem_rdata = $urandom;
    end
    check("alt_count_ok", order.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check($sformatf("alt_order%0d", i), order[i], (i % 2 == 0) ? 2 : 1);
    idle(4);

    // DM write: two write cycles, one ready, load data unchanged.
    saved = e_dm_rdata;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h80; bus.dm_wdata = 32'hDEADBEEF;
    we_cycles = 0; rdy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (bus.mem_we) begin
        we_cycles++;
        check("wr_addr", bus.mem_addr, 32'h80);
        check("wr_data", bus.mem_wdata, 32'hDEADBEEF);
      end
      if (bus.dm_ready) begin rdy_cnt++; bus.dm_req = 0; bus.dm_we = 0; end
      bus.mem_rdata = $urandom;
    end
    check("wr_we_cycles", we_cycles, MEM_LAT);
    check("wr_ready_cnt", rdy_cnt, 1);
    check("wr_rdata_kept", bus.dm_rdata, saved);
    idle(2);

    // Reset in the second busy cycle of a DM read; held request is re-granted after release.
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h44;
    cycle(); cycle();
    check("pre_rst_busy", bus.mem_en, 1'b1);
    #2 rst = 1;
    #1 model_reset();
    check("rst_mem_en", bus.mem_en, 1'b0);
    compare_all();
    cycle();
    rst = 0;
    cycle();
    check("regrant_mem_en", bus.mem_en, 1'b1);
    check("regrant_addr", bus.mem_addr, 32'h44);
    k = 0;
    while (!bus.dm_ready && k < 10) begin cycle(); k++; end
    check("regrant_ready", bus.dm_ready, 1'b1);
    idle(2);

    // Randomized requesters: hold until ready, then drop or re-issue immediately.
    for (int i = 0; i < 600; i++) begin
      cycle();
      bus.mem_rdata = $urandom;
      if (bus.if_req) begin
        if (e_if_ready) begin
          if ($urandom_range(1) == 0) bus.if_req = 0;
          else bus.if_addr = $urandom;
        end else if ($urandom_range(3) == 0) bus.if_addr = $urandom;
      end else if ($urandom_range(2) == 0) begin
        bus.if_req = 1; bus.if_addr = $urandom;
      end
      if (bus.dm_req) begin
        if (e_dm_ready) begin
          if ($urandom_range(1) == 0) begin bus.dm_req = 0; bus.dm_we = 0; end
          else begin
            bus.dm_we = ($urandom_range(2) == 0); bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
          end
        end else if ($urandom_range(3) == 0) begin
          bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
        end
      end else if ($urandom_range(2) == 0) begin
        bus.dm_req = 1; bus.dm_we = ($urandom_range(2) == 0);
        bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
      end
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
